mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive words per grant (legal range 1..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req, input, 4, per-requester request; bit i is held high while requester i has a word on its data input.
REQ-005 SHALL have ports a, b, c, d, input, 32 each, requester 0..3 data words.
REQ-006 SHALL have port port_ready, input, 1, shared memory port accepts data_out this cycle.
REQ-007 SHALL have port data_out, output, 32, registered word presented to the memory port.
REQ-008 SHALL have port valid, output, 1, data_out holds an unaccepted word.
REQ-009 SHALL have port gnt, output, 4, one-hot owner of the currently held word; all-zero when valid=0.
REQ-010 SHALL have port sel, output, 2, owner index (00=a, 01=b, 10=c, 11=d); drives the shared 4-way 32-bit mux select.
REQ-011 SHALL have port ack, output, 4, one-cycle pulse on bit i when requester i's word is captured into data_out.

Function
REQ-012 SHALL implement two states: IDLE (valid=0, no owner) and OWN (valid=1, owner defined).
REQ-013 SHALL define a load cycle as: any req bit high AND (valid=0 OR port_ready=1).
REQ-014 SHALL, in a load cycle, capture the selected input into data_out, set valid=1, set gnt/sel to the chosen index, and pulse ack at that index, all visible the next cycle (latency 1).
REQ-015 SHALL keep the same owner on a load if owner's req=1 and burst_cnt < MAX_BURST; burst_cnt increments on each such load.
REQ-016 SHALL otherwise arbitrate round-robin: search starts at last_owner+1 mod 4 and takes the first req bit high; the winner becomes owner with burst_cnt=1.
REQ-017 SHALL treat a requester that exhausted MAX_BURST as lowest priority; if it is the only requester it is re-granted and starts a new burst (burst_cnt=1).
REQ-018 SHALL, when valid=1 and port_ready=0, hold data_out, valid, gnt, sel and burst_cnt unchanged regardless of req; ack=0.
REQ-019 SHALL, when valid=1, port_ready=1 and req=0000, go to IDLE: valid=0, gnt=0000, ack=0000; sel and last_owner keep the previous owner index.
REQ-020 SHALL support back-to-back transfers with no bubble: acceptance and a new load occur in the same cycle.
REQ-021 SHALL never assert more than one gnt bit or more than one ack bit; ack bit i only when gnt bit i is set the following cycle.
REQ-022 SHALL ignore a req drop by the owner while its word is held; the held word is still delivered.
REQ-023 SHALL size burst_cnt at 4 bits and saturate rather than wrap.

Reset
REQ-024 SHALL, while rst_n=0 (asynchronously), force: state IDLE, data_out=0, valid=0, gnt=0000, sel=00, ack=0000, burst_cnt=0, last_owner=3 (requester 0 has first priority).
REQ-025 SHALL discard any held word on reset mid-transfer; no ack or valid may appear until a load after rst_n rises.

Verification
REQ-026 Reset release, req=0001, a=0x11111111, port_ready=1 -> next cycle data_out=0x11111111, valid=1, gnt=0001, sel=00, ack=0001.
REQ-027 req=1111 held, port_ready=1, MAX_BURST=4 -> owners 0,0,0,0,1,1,1,1,2,... with no idle cycle; ack pulses every cycle.
REQ-028 Owner 2 loaded (c=0xCAFEF00D), port_ready=0 for 5 cycles while req changes -> data_out, gnt=0100, sel=10 stable, ack=0000; first port_ready=1 cycle loads next word.
REQ-029 Only req[3] high for 10 cycles, port_ready=1 -> gnt=1000 every cycle; burst_cnt cycles 1..4 and restarts at 1.
REQ-030 last_owner=1, req=1001 on a load -> requester 3 wins (search order 2,3,0,1); gnt=1000, sel=11.
REQ-031 rst_n pulsed low mid-burst with valid=1 -> outputs at reset values immediately (without a clock edge); next load grants requester 0 first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - four-requester round-robin burst arbiter for a shared memory port
//
// Purpose: picks one of four 32-bit requesters and registers its word towards a
// shared memory port. The owner may stream up to MAX_BURST consecutive words
// before the grant rotates round-robin. A held word stays put while the port stalls.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req[3:0]    per-requester "word available" flags
//   a,b,c,d     requester 0..3 data words
//   port_ready  memory port accepts data_out this cycle
//   data_out    registered word presented to the port
//   valid       data_out holds an unaccepted word
//   gnt[3:0]    one-hot owner of the held word (zero when idle)
//   sel[1:0]    owner index, also the shared mux select
//   ack[3:0]    one-cycle pulse when a requester's word is captured

module mem_port_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   input  logic        port_ready,
   output logic [31:0] data_out,
   output logic        valid,
   output logic [3:0]  gnt,
   output logic [1:0]  sel,
   output logic [3:0]  ack
);

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   typedef enum logic {IDLE, OWN} state_t;

   state_t      state_q, state_d;
   logic [31:0] data_q, data_d;
   logic [1:0]  sel_q, sel_d;
   logic [1:0]  last_q, last_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  ack_q, ack_d;

   logic        load;
   logic        cont;
   logic        rr_found;
   logic [1:0]  rr_idx;
   logic [1:0]  cand;
   logic [1:0]  win;
   logic [31:0] win_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= 32'h0;
         sel_q   <= 2'd0;
         last_q  <= 2'd3;   // requester 0 gets first pick after reset
         cnt_q   <= 4'd0;
         ack_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
      end
   end

   // Winner selection: the current owner keeps the port while it still asks and
   // has burst budget left; otherwise search starts just after the last owner,
   // which naturally leaves an exhausted owner for last (k=4 wraps onto it).
   always_comb begin
      load     = (|req) && ((state_q == IDLE) || port_ready);
      cont     = (state_q == OWN) && req[sel_q] && (cnt_q < MAX_B);
      rr_found = 1'b0;
      rr_idx   = last_q;
      cand     = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!rr_found && req[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
      win = cont ? sel_q : rr_idx;
      case (win)
         2'd0:    win_data = a;
         2'd1:    win_data = b;
         2'd2:    win_data = c;
         default: win_data = d;
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      ack_d   = 4'd0;
      case (state_q)
         IDLE: begin
            if (load) state_d = OWN;
         end
         OWN: begin
            // Acceptance with nothing new to load drains to idle; the owner
            // index stays in sel/last so round-robin resumes after it.
            if (port_ready && !load) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         data_d = win_data;
         sel_d  = win;
         last_d = win;
         ack_d  = 4'b0001 << win;
         if (cont) cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
         else      cnt_d = 4'd1;
      end
   end

   assign data_out = data_q;
   assign valid    = (state_q == OWN);
   assign gnt      = valid ? (4'b0001 << sel_q) : 4'b0000;
   assign sel      = sel_q;
   assign ack      = ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

   localparam int MAXB = 4;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] a, b, c, d;
   logic        port_ready;
   logic [31:0] data_out;
   logic        valid;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic [3:0]  ack;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.MAX_BURST(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .a(a), .b(b), .c(c), .d(d),
      .port_ready(port_ready),
      .data_out(data_out), .valid(valid), .gnt(gnt), .sel(sel), .ack(ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner/burst bookkeeping as plain integers
   bit        m_valid;
   int        m_owner;
   int        m_last;
   int        m_cnt;
   logic [31:0] m_data;
   int        m_ack_idx;   // -1 when no ack this cycle

   function automatic logic [31:0] word_of(input int i);
      case (i)
         0: return a;
         1: return b;
         2: return c;
         default: return d;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 0; m_owner = 0; m_last = 3; m_cnt = 0; m_data = 0; m_ack_idx = -1;
      end else begin
         int w;
         m_ack_idx = -1;
         if (req != 4'b0 && (!m_valid || port_ready)) begin
            if (m_valid && req[m_owner] && m_cnt < MAXB) begin
               w = m_owner;
               m_cnt = m_cnt + 1;
            end else begin
               w = -1;
               for (int k = 1; k <= 4; k++)
                  if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
               m_cnt = 1;
            end
            m_data = word_of(w);
            m_owner = w;
            m_last = w;
            m_valid = 1;
            m_ack_idx = w;
         end else if (m_valid && port_ready) begin
            m_valid = 0;
         end
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      chk("valid", {31'b0, valid}, {31'b0, m_valid});
      chk("gnt", {28'b0, gnt}, m_valid ? (32'd1 << m_owner) : 32'd0);
      chk("sel", {30'b0, sel}, 32'(m_owner));
      chk("ack", {28'b0, ack}, (m_ack_idx < 0) ? 32'd0 : (32'd1 << m_ack_idx));
      if (m_valid) chk("data_out", data_out, m_data);
   end

   task automatic tick(input logic [3:0] r, input logic pr);
      req = r;
      port_ready = pr;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 4'b0;
      port_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [3:0] hold_req [5];
   int         exp_own  [13];

   initial begin
      hold_req = '{4'b0000, 4'b1011, 4'b0001, 4'b1111, 4'b0010};
      exp_own  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
      a = 32'h11111111; b = 32'h22222222; c = 32'hCAFEF00D; d = 32'h44444444;
      req = 4'b0; port_ready = 1'b0; rst_n = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_data", data_out, 32'd0);
      chk("rst_gnt", {28'b0, gnt}, 32'd0);
      chk("rst_ack", {28'b0, ack}, 32'd0);
      rst_n = 1'b1;

      // first load after reset
      tick(4'b0001, 1'b1);
      chk("first_data", data_out, 32'h11111111);
      chk("first_valid", {31'b0, valid}, 32'd1);
      chk("first_gnt", {28'b0, gnt}, 32'h1);
      chk("first_sel", {30'b0, sel}, 32'd0);
      chk("first_ack", {28'b0, ack}, 32'h1);

      // all requesting: bursts of four, rotating, no bubble
      do_reset();
      for (int i = 0; i < 13; i++) begin
         tick(4'b1111, 1'b1);
         chk("rr_sel", {30'b0, sel}, 32'(exp_own[i]));
         chk("rr_ack", {28'b0, ack}, 32'd1 << exp_own[i]);
      end

      // owner 2 stalled while req wiggles, including its own drop
      do_reset();
      tick(4'b0100, 1'b0);
      chk("stall_load_ack", {28'b0, ack}, 32'h4);
      for (int i = 0; i < 5; i++) begin
         tick(hold_req[i], 1'b0);
         chk("stall_data", data_out, 32'hCAFEF00D);
         chk("stall_gnt", {28'b0, gnt}, 32'h4);
         chk("stall_sel", {30'b0, sel}, 32'd2);
         chk("stall_ack", {28'b0, ack}, 32'd0);
      end
      tick(4'b0001, 1'b1);
      chk("stall_next_gnt", {28'b0, gnt}, 32'h1);
      chk("stall_next_data", data_out, 32'h11111111);

      // lone requester 3 re-granted every cycle across burst boundaries
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(4'b1000, 1'b1);
         chk("solo_gnt", {28'b0, gnt}, 32'h8);
         chk("solo_ack", {28'b0, ack}, 32'h8);
      end
      tick(4'b0000, 1'b1);
      chk("idle_valid", {31'b0, valid}, 32'd0);
      chk("idle_gnt", {28'b0, gnt}, 32'd0);
      chk("idle_sel", {30'b0, sel}, 32'd3);

      // last owner 1, req 1001 -> requester 3
      do_reset();
      tick(4'b0010, 1'b1);
      tick(4'b1001, 1'b1);
      chk("search_gnt", {28'b0, gnt}, 32'h8);
      chk("search_sel", {30'b0, sel}, 32'd3);

      // asynchronous reset mid-burst
      do_reset();
      tick(4'b1111, 1'b1);
      tick(4'b1111, 1'b1);
      tick(4'b1111, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", {31'b0, valid}, 32'd0);
      chk("async_gnt", {28'b0, gnt}, 32'd0);
      chk("async_ack", {28'b0, ack}, 32'd0);
      chk("async_data", data_out, 32'd0);
      chk("async_sel", {30'b0, sel}, 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      tick(4'b1111, 1'b1);
      chk("post_rst_gnt", {28'b0, gnt}, 32'h1);

      tick(4'b0000, 1'b1);
      tick(4'b0000, 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
